serial_receiver: RTL and testbench
==================================

SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 SHALL have parameter CLOCKS_PER_BIT, default 52, core_clock cycles per serial bit (even, >=4).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, received-byte buffer entries (power of two, >=2).
REQ-003 SHALL have port core_clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset, sampled on core_clock.
REQ-005 SHALL have port serial_rx  input  1  asynchronous UART line; idle high; 8N1 frames, LSB first.
REQ-006 SHALL have port rx_data  output  8  byte at FIFO head.
REQ-007 SHALL have port rx_data_available  output  1  high while FIFO non-empty.
REQ-008 SHALL have port rx_data_consumed  input  1  pop request; pops head when rx_data_available is high.
REQ-009 SHALL have port framing_error  output  1  sticky; stop bit sampled low.
REQ-010 SHALL have port overrun_error  output  1  sticky; valid byte dropped because FIFO full.
REQ-011 SHALL have port clear_errors  input  1  clears both sticky flags.

Function
REQ-012 SHALL pass serial_rx through a 2-flop synchronizer; all decisions use the synchronized value (rx_s).
REQ-013 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE with one bit counter (0..CLOCKS_PER_BIT-1) and one 3-bit index.
REQ-014 IDLE: rx_s low -> START, counter cleared.
REQ-015 START: at counter == CLOCKS_PER_BIT/2-1, sample rx_s; high -> IDLE (glitch, no flag); low -> DATA, index 0, counter cleared.
REQ-016 DATA: at counter == CLOCKS_PER_BIT-1, shift rx_s into bit[index]; index 7 -> STOP, else index+1; counter cleared.
REQ-017 STOP: at counter == CLOCKS_PER_BIT-1, sample rx_s; high -> push byte, go IDLE; low -> discard byte, set framing_error, go WAIT_IDLE.
REQ-018 WAIT_IDLE: remain until rx_s high, then IDLE.
REQ-019 Push SHALL be accepted if FIFO not full, or if full and a pop occurs the same cycle; otherwise byte dropped, overrun_error set, FIFO unchanged.
REQ-020 Pushed byte SHALL appear on rx_data with rx_data_available high on the cycle after the push edge (when FIFO was empty).
REQ-021 Pop SHALL occur on an edge where rx_data_available && rx_data_consumed; rx_data_consumed with FIFO empty SHALL be ignored.
REQ-022 rx_data SHALL be stable while rx_data_available is high and no pop occurs; value undefined-but-held when empty.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy count 0..FIFO_DEPTH, simultaneous push+pop leaves count unchanged.
REQ-024 clear_errors SHALL clear flags next edge; a set event in the same cycle as clear_errors SHALL win (flag stays high).
REQ-025 Framing and overrun errors SHALL NOT affect FIFO contents or subsequent frame reception.

Reset
REQ-026 On reset: state WAIT_IDLE, synchronizer flops 1, counters 0, FIFO empty, rx_data 8'h00, rx_data_available 0, framing_error 0, overrun_error 0.
REQ-027 Reset mid-frame SHALL abandon the partial byte with no push and no flag; reception resumes only after rx_s high.
REQ-028 Reset SHALL take priority over all other inputs in the same cycle.

Verification (CLOCKS_PER_BIT=8, FIFO_DEPTH=4)
REQ-029 Drive frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> rx_data=0xA5, rx_data_available high, no flags; pulse rx_data_consumed -> available low.
REQ-030 Low pulse of 3 cycles on idle line -> state returns IDLE, no push, no flags; following frame 0x3C received correctly.
REQ-031 Frame 0x55 with stop bit 0, then line held low 20 cycles, then frame 0x12 -> framing_error=1, only 0x12 in FIFO.
REQ-032 Send 5 frames 0x01..0x05 without consuming -> FIFO holds 0x01..0x04, overrun_error=1; pop with push of 5th on same edge -> 0x05 accepted, no overrun.
REQ-033 Assert clear_errors with both flags set -> both 0 next cycle; concurrent new framing error -> framing_error stays 1.
REQ-034 Assert reset during DATA bit 4 of frame 0xFF, release while line low -> no push; next full frame 0x81 after idle received as 0x81.

Source files
------------

// File: rtl/serial_receiver.sv
// serial_receiver: 8N1 UART receiver with a byte FIFO and sticky framing/overrun flags
module serial_receiver #(
   parameter int CLOCKS_PER_BIT = 52,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       core_clock,
   input  logic       reset,
   input  logic       serial_rx,
   output logic [7:0] rx_data,
   output logic       rx_data_available,
   input  logic       rx_data_consumed,
   output logic       framing_error,
   output logic       overrun_error,
   input  logic       clear_errors
);
   localparam int CW = $clog2(CLOCKS_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] BIT_END = CW'(CLOCKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_END = CW'(CLOCKS_PER_BIT / 2 - 1);
   localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
   state_t state;
   logic rx_m, rx_s;
   logic [CW-1:0] count;
   logic [2:0] index;
   logic [7:0] shift;
   logic [7:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] level;
   logic stop_end, push, pop, accept;
   assign stop_end = state == STOP && count == BIT_END;
   assign push = stop_end && rx_s;
   assign pop = rx_data_available && rx_data_consumed;
   // a full FIFO still takes the byte when the head leaves on the same edge
   assign accept = push && (level != FULL || pop);
   assign rx_data = mem[rd_ptr];
   assign rx_data_available = level != '0;
   always_ff @(posedge core_clock) begin
      if (reset) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         state <= WAIT_IDLE;
         count <= '0;
         index <= '0;
         shift <= '0;
      end else begin
         rx_m <= serial_rx;
         rx_s <= rx_m;
         count <= count + CW'(1);
         case (state)
            IDLE: begin
               count <= '0;
               state <= rx_s ? IDLE : START;
            end
            START: if (count == HALF_END) begin
               state <= rx_s ? IDLE : DATA;
               index <= '0;
               count <= '0;
            end
            DATA: if (count == BIT_END) begin
               shift[index] <= rx_s;
               index <= index + 3'd1;
               count <= '0;
               state <= index == 3'd7 ? STOP : DATA;
            end
            STOP: if (count == BIT_END) begin
               state <= rx_s ? IDLE : WAIT_IDLE;
               count <= '0;
            end
            WAIT_IDLE: begin
               count <= '0;
               state <= rx_s ? IDLE : WAIT_IDLE;
            end
            default: state <= WAIT_IDLE;
         endcase
      end
   end
   always_ff @(posedge core_clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level <= '0;
         framing_error <= 1'b0;
         overrun_error <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (accept) begin
            mem[wr_ptr] <= shift;
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         level <= level + (AW+1)'(accept) - (AW+1)'(pop);
         framing_error <= (stop_end && !rx_s) || (framing_error && !clear_errors);
         overrun_error <= (push && !accept) || (overrun_error && !clear_errors);
      end
   end
endmodule

// File: tb/tb_serial_receiver.sv
// tb_serial_receiver: directed frame tests for serial_receiver at 8 clocks per bit, 4-deep FIFO
module tb_serial_receiver;
   logic core_clock = 1'b0;
   logic reset = 1'b1;
   logic serial_rx = 1'b1;
   logic [7:0] rx_data;
   logic rx_data_available;
   logic rx_data_consumed = 1'b0;
   logic framing_error;
   logic overrun_error;
   logic clear_errors = 1'b0;
   int passed = 0;
   int total = 0;

   serial_receiver #(.CLOCKS_PER_BIT(8), .FIFO_DEPTH(4)) dut (
      .core_clock(core_clock),
      .reset(reset),
      .serial_rx(serial_rx),
      .rx_data(rx_data),
      .rx_data_available(rx_data_available),
      .rx_data_consumed(rx_data_consumed),
      .framing_error(framing_error),
      .overrun_error(overrun_error),
      .clear_errors(clear_errors)
   );

   always #5 core_clock = ~core_clock;

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge core_clock);
   endtask

   task automatic idle(input int n);
      serial_rx = 1'b1;
      tick(n);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      serial_rx = 1'b1;
      tick(2);
      reset = 1'b0;
      idle(4);
   endtask

   // the edge that samples the stop bit is the 79th after the start bit is driven
   task automatic send_frame(input logic [7:0] d, input logic stop, input int pop_at, input int clr_at);
      logic [9:0] bits;
      bits = {stop, d, 1'b0};
      for (int i = 0; i < 80; i++) begin
         @(negedge core_clock);
         serial_rx = bits[i/8];
         rx_data_consumed = i == pop_at;
         clear_errors = i == clr_at;
      end
      @(negedge core_clock);
      rx_data_consumed = 1'b0;
      clear_errors = 1'b0;
   endtask

   task automatic pop_byte();
      rx_data_consumed = 1'b1;
      tick(1);
      rx_data_consumed = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      serial_rx = 1'b0;
      rx_data_consumed = 1'b1;
      clear_errors = 1'b0;
      tick(3);
      total++; if (rx_data !== 8'h00) $display("FAIL reset_data: got %h want 00", rx_data); else passed++;
      total++; if (rx_data_available !== 1'b0) $display("FAIL reset_avail: got %b want 0", rx_data_available); else passed++;
      total++; if (framing_error !== 1'b0) $display("FAIL reset_fe: got %b want 0", framing_error); else passed++;
      total++; if (overrun_error !== 1'b0) $display("FAIL reset_oe: got %b want 0", overrun_error); else passed++;
      reset = 1'b0;
      rx_data_consumed = 1'b0;
      idle(12);
      total++; if (rx_data_available !== 1'b0) $display("FAIL reset_after_avail: got %b want 0", rx_data_available); else passed++;
   endtask

   task automatic test_basic();
      apply_reset();
      pop_byte();
      send_frame(8'hA5, 1'b1, -1, -1);
      total++; if (rx_data_available !== 1'b1) $display("FAIL a5_latency_avail: got %b want 1", rx_data_available); else passed++;
      idle(4);
      total++; if (rx_data !== 8'hA5) $display("FAIL a5_data: got %h want a5", rx_data); else passed++;
      total++; if (framing_error !== 1'b0 || overrun_error !== 1'b0) $display("FAIL a5_flags: got %b%b want 00", framing_error, overrun_error); else passed++;
      idle(20);
      total++; if (rx_data !== 8'hA5 || rx_data_available !== 1'b1) $display("FAIL a5_hold: got %h/%b want a5/1", rx_data, rx_data_available); else passed++;
      pop_byte();
      total++; if (rx_data_available !== 1'b0) $display("FAIL a5_pop_avail: got %b want 0", rx_data_available); else passed++;
   endtask

   task automatic test_glitch();
      apply_reset();
      serial_rx = 1'b0;
      tick(3);
      idle(12);
      total++; if (rx_data_available !== 1'b0) $display("FAIL glitch_avail: got %b want 0", rx_data_available); else passed++;
      total++; if (framing_error !== 1'b0 || overrun_error !== 1'b0) $display("FAIL glitch_flags: got %b%b want 00", framing_error, overrun_error); else passed++;
      send_frame(8'h3C, 1'b1, -1, -1);
      idle(4);
      total++; if (rx_data !== 8'h3C || rx_data_available !== 1'b1) $display("FAIL glitch_3c: got %h/%b want 3c/1", rx_data, rx_data_available); else passed++;
      total++; if (framing_error !== 1'b0) $display("FAIL glitch_3c_fe: got %b want 0", framing_error); else passed++;
      pop_byte();
      total++; if (rx_data_available !== 1'b0) $display("FAIL glitch_pop_avail: got %b want 0", rx_data_available); else passed++;
   endtask

   task automatic test_framing();
      apply_reset();
      send_frame(8'h55, 1'b0, -1, -1);
      tick(20);
      total++; if (framing_error !== 1'b1) $display("FAIL frm_fe: got %b want 1", framing_error); else passed++;
      total++; if (rx_data_available !== 1'b0) $display("FAIL frm_no_push: got %b want 0", rx_data_available); else passed++;
      idle(4);
      send_frame(8'h12, 1'b1, -1, -1);
      idle(4);
      total++; if (rx_data !== 8'h12 || rx_data_available !== 1'b1) $display("FAIL frm_12: got %h/%b want 12/1", rx_data, rx_data_available); else passed++;
      total++; if (framing_error !== 1'b1 || overrun_error !== 1'b0) $display("FAIL frm_flags: got %b%b want 10", framing_error, overrun_error); else passed++;
      pop_byte();
      total++; if (rx_data_available !== 1'b0) $display("FAIL frm_only_one: got %b want 0", rx_data_available); else passed++;
   endtask

   task automatic test_overrun();
      logic [7:0] want;
      apply_reset();
      for (int k = 1; k <= 5; k++) begin
         send_frame(8'(k), 1'b1, -1, -1);
         idle(2);
      end
      total++; if (overrun_error !== 1'b1) $display("FAIL ovr_oe: got %b want 1", overrun_error); else passed++;
      total++; if (rx_data !== 8'h01 || rx_data_available !== 1'b1) $display("FAIL ovr_head: got %h/%b want 01/1", rx_data, rx_data_available); else passed++;
      total++; if (framing_error !== 1'b0) $display("FAIL ovr_fe: got %b want 0", framing_error); else passed++;
      clear_errors = 1'b1;
      tick(1);
      clear_errors = 1'b0;
      total++; if (overrun_error !== 1'b0) $display("FAIL ovr_clear: got %b want 0", overrun_error); else passed++;
      send_frame(8'h05, 1'b1, 78, -1);
      idle(4);
      total++; if (overrun_error !== 1'b0) $display("FAIL ovr_pop_push_oe: got %b want 0", overrun_error); else passed++;
      for (int k = 2; k <= 5; k++) begin
         want = 8'(k);
         total++; if (rx_data !== want || rx_data_available !== 1'b1) $display("FAIL ovr_drain%0d: got %h/%b want %h/1", k, rx_data, rx_data_available, want); else passed++;
         pop_byte();
      end
      total++; if (rx_data_available !== 1'b0) $display("FAIL ovr_empty: got %b want 0", rx_data_available); else passed++;
   endtask

   task automatic test_clear();
      apply_reset();
      for (int k = 0; k < 5; k++) begin
         send_frame(8'h11 + 8'(k), 1'b1, -1, -1);
         idle(2);
      end
      send_frame(8'h77, 1'b0, -1, -1);
      idle(4);
      total++; if (framing_error !== 1'b1 || overrun_error !== 1'b1) $display("FAIL clr_both_set: got %b%b want 11", framing_error, overrun_error); else passed++;
      clear_errors = 1'b1;
      tick(1);
      clear_errors = 1'b0;
      total++; if (framing_error !== 1'b0 || overrun_error !== 1'b0) $display("FAIL clr_both_cleared: got %b%b want 00", framing_error, overrun_error); else passed++;
      send_frame(8'h66, 1'b0, -1, 78);
      idle(4);
      total++; if (framing_error !== 1'b1) $display("FAIL clr_set_wins: got %b want 1", framing_error); else passed++;
      total++; if (overrun_error !== 1'b0) $display("FAIL clr_oe_stays: got %b want 0", overrun_error); else passed++;
      total++; if (rx_data !== 8'h11 || rx_data_available !== 1'b1) $display("FAIL clr_fifo_kept: got %h/%b want 11/1", rx_data, rx_data_available); else passed++;
   endtask

   task automatic test_reset_midframe();
      apply_reset();
      serial_rx = 1'b0;
      tick(8);
      serial_rx = 1'b1;
      tick(36);
      reset = 1'b1;
      serial_rx = 1'b0;
      tick(3);
      reset = 1'b0;
      tick(2);
      idle(12);
      total++; if (rx_data_available !== 1'b0) $display("FAIL mid_no_push: got %b want 0", rx_data_available); else passed++;
      total++; if (framing_error !== 1'b0 || overrun_error !== 1'b0) $display("FAIL mid_flags: got %b%b want 00", framing_error, overrun_error); else passed++;
      send_frame(8'h81, 1'b1, -1, -1);
      idle(4);
      total++; if (rx_data !== 8'h81 || rx_data_available !== 1'b1) $display("FAIL mid_81: got %h/%b want 81/1", rx_data, rx_data_available); else passed++;
      pop_byte();
      total++; if (rx_data_available !== 1'b0) $display("FAIL mid_single: got %b want 0", rx_data_available); else passed++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_framing();
      test_overrun();
      test_clear();
      test_reset_midframe();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
